// File: rtl/overlap_pkg.sv
// Shared types and helpers for the multichannel IMDCT overlap-add stage.
//  - overlap_mode_e : block mode carried with the first sample of a block
//  - S_ADD/S_STORE  : FSM state encodings (first half adds, second half stores)
//  - decode_mode    : maps the raw 2-bit mode input, folding 2'b11 to normal
//  - sat_add        : signed add clamped to a w-bit two's-complement range
package overlap_pkg;

  typedef enum logic [1:0] {
    OV_NORMAL = 2'b00,
    OV_FIRST  = 2'b01,
    OV_FLUSH  = 2'b10
  } overlap_mode_e;

  localparam logic [0:0] S_ADD   = 1'b0;
  localparam logic [0:0] S_STORE = 1'b1;

  function automatic overlap_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return OV_FIRST;
      2'b10:   return OV_FLUSH;
      default: return OV_NORMAL;
    endcase
  endfunction

  // Operands arrive sign-extended to 64 bits, so the sum cannot overflow for
  // w <= 63; the result is clamped to [-2^(w-1), 2^(w-1)-1] and the caller
  // keeps the low w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (sum > max_v)      return max_v;
    else if (sum < min_v) return min_v;
    else                  return sum;
  endfunction

endpackage

// File: rtl/overlap_hist_mem.sv
// History bank for the overlap-add stage: DEPTH words of DATA_W bits held in
// flops, one combinational read port and one synchronous write port.
//  clk      : rising-edge clock
//  reset    : asynchronous active-low, clears every word
//  rd_addr  : read address, rd_data follows combinationally
//  wr_en    : write strobe, wr_data lands at wr_addr on the next edge
module overlap_hist_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 36,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // The top only issues in-range addresses, so no bounds guard is needed here.
  assign rd_data = mem_q[rd_addr];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/overlap_add_mc.sv
// Multichannel IMDCT overlap-add. Each block carries 2*HALF_LEN windowed
// samples; the first half is added to that channel's stored second half of
// the previous block and emitted as PCM, the second half replaces the history.
//  in_overlap_*  : sample input, valid/ready; channel and mode sampled with the
//                  first sample of a block and held for the whole block
//  out_overlap_* : PCM output, valid/ready, registered (1-cycle latency)
//  dbg_state     : current FSM state (S_ADD/S_STORE)
// Handshake: a transfer happens on any edge where valid && ready; a source
// never drops valid without a transfer, and out data stays stable while
// out_overlap_valid && !out_overlap_ready.
module overlap_add_mc
  import overlap_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int HALF_LEN = 18,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W   = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1,
  localparam int DEPTH   = CHANNELS * HALF_LEN,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        in_overlap_firstSequence,
  input  logic [CH_W-1:0]   in_overlap_channel,
  input  logic [DATA_W-1:0] in_overlap_pcmSample,
  input  logic              in_overlap_valid,
  output logic              in_overlap_ready,
  output logic [DATA_W-1:0] out_overlap_pcmSample,
  output logic [CH_W-1:0]   out_overlap_channel,
  output logic              out_overlap_last,
  output logic              out_overlap_valid,
  input  logic              out_overlap_ready,
  output logic              dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_LEN - 1);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  overlap_mode_e     mode_q, mode_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] out_pcm_q, out_pcm_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              blk_start, ch_ok, in_xfer, add_xfer, st_xfer;
  overlap_mode_e     cur_mode;
  logic [CH_W-1:0]   cur_ch;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rd_data, hist_rd, wr_data;
  logic              wr_en;

  overlap_hist_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_hist (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (mem_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (mem_addr),
    .wr_data (wr_data)
  );

  always_comb begin
    // Mode and channel come straight from the inputs only on the first sample
    // of a block; everywhere else the latched copies are used.
    blk_start = (state_q == S_ADD) && (idx_q == '0);
    cur_mode  = blk_start ? decode_mode(in_overlap_firstSequence) : mode_q;
    cur_ch    = blk_start ? in_overlap_channel : ch_q;
    // Store phase never waits on downstream; add phase needs a free out slot.
    // Gating with reset keeps ready low while reset is held.
    in_overlap_ready = reset && ((state_q == S_STORE) || !out_valid_q || out_overlap_ready);
    in_xfer  = in_overlap_valid && in_overlap_ready;
    add_xfer = in_xfer && (state_q == S_ADD);
    st_xfer  = in_xfer && (state_q == S_STORE);
    // Channel codes beyond CHANNELS (non power-of-two counts) read zero and
    // never write, rather than aliasing onto another channel's history.
    ch_ok    = int'(cur_ch) < CHANNELS;
    mem_addr = ch_ok ? ADDR_W'(int'(cur_ch) * HALF_LEN + int'(idx_q)) : '0;
    hist_rd  = ((cur_mode == OV_FIRST) || !ch_ok) ? '0 : rd_data;
    wr_en    = st_xfer && ch_ok;
    wr_data  = (mode_q == OV_FLUSH) ? '0 : in_overlap_pcmSample;

    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    ch_d        = ch_q;
    out_pcm_d   = out_pcm_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (in_xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = (state_q == S_ADD) ? S_STORE : S_ADD;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (add_xfer && blk_start) begin
      mode_d = cur_mode;
      ch_d   = cur_ch;
    end

    if (add_xfer) begin
      out_pcm_d   = DATA_W'(sat_add(64'(signed'(in_overlap_pcmSample)),
                                    64'(signed'(hist_rd)), DATA_W));
      out_ch_d    = cur_ch;
      out_last_d  = (idx_q == LAST_IDX);
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_overlap_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_ADD;
      idx_q       <= '0;
      mode_q      <= OV_NORMAL;
      ch_q        <= '0;
      out_pcm_q   <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      out_pcm_q   <= out_pcm_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_overlap_pcmSample = out_pcm_q;
  assign out_overlap_channel   = out_ch_q;
  assign out_overlap_last      = out_last_q;
  assign out_overlap_valid     = out_valid_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_overlap_add_mc.sv
// Bench for overlap_add_mc: a driver task feeds 2*HL-sample blocks, pushing the
// expected {last, channel, pcm} word for each first-half sample computed from
// a bench-side history model; a negedge monitor pops and compares every
// output transfer and checks that stalled output data stays stable.
module tb_overlap_add_mc;

  localparam int DW = 32;
  localparam int HL = 18;
  localparam int CH = 2;
  localparam int EW = DW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    in_mode;
  logic [0:0]    in_ch;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_pcm;
  logic [0:0]    out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          dbg_state;

  always #5 clk = ~clk;

  overlap_add_mc #(.DATA_W(DW), .HALF_LEN(HL), .CHANNELS(CH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_overlap_firstSequence (in_mode),
    .in_overlap_channel       (in_ch),
    .in_overlap_pcmSample     (in_sample),
    .in_overlap_valid         (in_valid),
    .in_overlap_ready         (in_ready),
    .out_overlap_pcmSample    (out_pcm),
    .out_overlap_channel      (out_ch),
    .out_overlap_last         (out_last),
    .out_overlap_valid        (out_valid),
    .out_overlap_ready        (out_ready),
    .dbg_state                (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  logic signed [DW-1:0] hist_m [CH][HL];
  logic signed [DW-1:0] blk [2*HL];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_sat(input longint a, input longint b);
    longint s;
    longint max_v;
    longint min_v;
    s     = a + b;
    max_v = (longint'(1) << (DW - 1)) - 1;
    min_v = -(longint'(1) << (DW - 1));
    if (s > max_v) s = max_v;
    if (s < min_v) s = min_v;
    return s[DW-1:0];
  endfunction

  // Monitor: compare every output transfer, and check held data on stalls.
  logic          stall_seen = 1'b0;
  logic [EW-1:0] stall_word;
  always @(negedge clk) begin
    if (reset) begin
      if (stall_seen) check("hold_stable", {out_last, out_ch, out_pcm}, stall_word);
      stall_seen = 1'b0;
      if (out_valid && !out_ready) begin
        stall_seen = 1'b1;
        stall_word = {out_last, out_ch, out_pcm};
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("out_data", {out_last, out_ch, out_pcm}, exp_q.pop_front());
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // Drives one block. store_stall holds out_ready low for the whole store
  // half; abort_at >= 0 asserts reset just before that sample index.
  task automatic send_block(input int ch, input int mode, input bit store_stall,
                            input int abort_at);
    int n;
    for (int i = 0; i < 2 * HL; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_pcm", out_pcm, 0);
        check("abort_state", dbg_state, 0);
        exp_q.delete();
        for (int c = 0; c < CH; c++)
          for (int j = 0; j < HL; j++) hist_m[c][j] = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
      if (store_stall && i == HL) out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sample = blk[i];
      if (i == 0) begin
        in_ch   = 1'(ch);
        in_mode = 2'(mode);
      end else begin
        // Junk on the sideband: it must be ignored mid-block.
        in_ch   = 1'($urandom_range(0, 1));
        in_mode = 2'($urandom_range(0, 3));
      end
      if (i < HL)
        exp_q.push_back({(i == HL - 1), 1'(ch),
                         model_sat(longint'(blk[i]),
                                   (mode == 1) ? 0 : longint'(hist_m[ch][i]))});
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check("in_ready_timeout", 0, 1);
      if (store_stall && i >= HL) check("store_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int j = 0; j < HL; j++) hist_m[ch][j] = (mode == 2) ? '0 : blk[HL + j];
    if (store_stall) begin
      check("store_held_valid", out_valid, 1);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int n;
    in_mode   = 2'b00;
    in_ch     = 1'b0;
    in_sample = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < HL; j++) hist_m[c][j] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_pcm", out_pcm, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First block, ch0: outputs 1..18, history becomes 19..36.
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'(i + 1);
    send_block(0, 1, 0, -1);
    // Normal block of 100s: outputs 119..136.
    for (int i = 0; i < 2 * HL; i++) blk[i] = 100;
    send_block(0, 0, 0, -1);
    // ch1 first-of-stream with 5s, then ch0 again must add its own 100s.
    for (int i = 0; i < 2 * HL; i++) blk[i] = 5;
    send_block(1, 1, 0, -1);
    for (int i = 0; i < 2 * HL; i++) blk[i] = 100;
    send_block(0, 0, 0, -1);
    // Mode 11 behaves as normal.
    send_block(0, 3, 0, -1);

    // Saturation on ch1: positive clamp, then negative clamp.
    for (int i = 0; i < HL; i++) begin
      blk[i] = 0;
      blk[HL + i] = 32'h7FFF_FFF0;
    end
    send_block(1, 1, 0, -1);
    for (int i = 0; i < HL; i++) begin
      blk[i] = 32'h0000_0100;
      blk[HL + i] = 32'h8000_0000;
    end
    send_block(1, 0, 0, -1);
    for (int i = 0; i < 2 * HL; i++) blk[i] = 32'hFFFF_FFFF;
    send_block(1, 0, 0, -1);

    // Downstream stall mid add phase.
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'($urandom_range(0, 65535));
    fork
      send_block(0, 0, 0, -1);
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    // Downstream stall across the whole store phase.
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'($urandom());
    send_block(1, 0, 1, -1);

    // Flush, then the next block outputs its raw first half.
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'($urandom_range(0, 1000));
    send_block(0, 2, 0, -1);
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'($urandom_range(0, 1000));
    send_block(0, 0, 0, -1);

    // Reset at idx 7 of the store phase, then a block of 1s outputs 1s.
    for (int i = 0; i < 2 * HL; i++) blk[i] = DW'($urandom_range(0, 1000));
    send_block(1, 0, 0, HL + 7);
    for (int i = 0; i < 2 * HL; i++) blk[i] = 1;
    send_block(1, 0, 0, -1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
